// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver: assembles WIDTH strobed bits framed by a
// start marker and presents each word through a one-entry valid/ready buffer.
module sipo_frame_receiver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_din,
    input  logic             bit_en,
    input  logic             frame_start,
    input  logic             dir,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             dir_q, dir_n;
    logic [WIDTH-1:0] p_dout_n;
    logic             p_valid_n;
    logic             frame_err_n;
    logic             overrun_n;
    logic             complete_c;
    logic [WIDTH-1:0] shift_new_c;
    logic [WIDTH-1:0] shift_cur_c;

    // Shift candidates: a fresh frame uses the incoming dir, a running frame the latched one.
    always_comb begin
        shift_new_c = dir   ? {sr[WIDTH-2:0], s_din} : {s_din, sr[WIDTH-1:1]};
        shift_cur_c = dir_q ? {sr[WIDTH-2:0], s_din} : {s_din, sr[WIDTH-1:1]};
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_n     = state;
        sr_n        = sr;
        cnt_n       = cnt;
        dir_n       = dir_q;
        p_dout_n    = p_dout;
        p_valid_n   = p_valid;
        frame_err_n = 1'b0;
        overrun_n   = overrun;
        complete_c  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bit_en && frame_start) begin
                    dir_n   = dir;
                    sr_n    = shift_new_c;
                    cnt_n   = CW'(1);
                    state_n = RECV;
                end
            end
            RECV: begin
                if (bit_en && frame_start) begin
                    frame_err_n = 1'b1;
                    dir_n       = dir;
                    sr_n        = shift_new_c;
                    cnt_n       = CW'(1);
                end else if (bit_en) begin
                    sr_n = shift_cur_c;
                    if (cnt == CW'(WIDTH - 1)) begin
                        complete_c = 1'b1;
                        cnt_n      = '0;
                        state_n    = IDLE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (p_valid && p_ready) begin
            p_valid_n = 1'b0;
        end
        if (ovr_clr) begin
            overrun_n = 1'b0;
        end
        // A completing word lands if the slot is empty or drains this cycle; otherwise it is lost.
        if (complete_c) begin
            if (!p_valid || p_ready) begin
                p_dout_n  = shift_cur_c;
                p_valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            dir_q     <= 1'b0;
            p_dout    <= '0;
            p_valid   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            cnt       <= cnt_n;
            dir_q     <= dir_n;
            p_dout    <= p_dout_n;
            p_valid   <= p_valid_n;
            busy      <= (state_n == RECV);
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver (WIDTH=8) with hand-computed words.
module tb_sipo_frame_receiver;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             s_din;
    logic             bit_en;
    logic             frame_start;
    logic             dir;
    logic [WIDTH-1:0] p_dout;
    logic             p_valid;
    logic             p_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;
    logic             ovr_clr;

    int vectors;
    int miscompares;

    sipo_frame_receiver #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_din       (s_din),
        .bit_en      (bit_en),
        .frame_start (frame_start),
        .dir         (dir),
        .p_dout      (p_dout),
        .p_valid     (p_valid),
        .p_ready     (p_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bit per strobe; optional idle gaps; dir is toggled after bit 0 to show it is held.
    task automatic send_word(input logic [7:0] w, input logic d, input bit gaps,
                             input logic err0, input logic ready_last, input bit chk_empty);
        for (int i = 0; i < 8; i++) begin
            if (gaps && i > 0) begin
                for (int g = 0; g < (i % 3); g++) begin
                    tick();
                    chk("gap_busy", 32'(busy), 32'd1);
                    chk("gap_valid", 32'(p_valid), 32'd0);
                end
            end
            if (i == 7) p_ready = ready_last;
            s_din       = d ? w[7-i] : w[i];
            frame_start = (i == 0);
            dir         = (i == 0) ? d : ~d;
            bit_en      = 1'b1;
            tick();
            bit_en      = 1'b0;
            frame_start = 1'b0;
            if (i == 0) chk("frame_err_bit0", 32'(frame_err), 32'(err0));
            if (i == 1) chk("frame_err_bit1", 32'(frame_err), 32'd0);
            if (i < 7) begin
                chk("busy_mid", 32'(busy), 32'd1);
                if (chk_empty) chk("valid_mid", 32'(p_valid), 32'd0);
            end else begin
                chk("busy_end", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        logic [4:0] partial;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        s_din       = 1'b0;
        bit_en      = 1'b0;
        frame_start = 1'b0;
        dir         = 1'b0;
        p_ready     = 1'b0;
        ovr_clr     = 1'b0;
        tick();
        tick();
        chk("rst_dout", 32'(p_dout), 32'h0);
        chk("rst_valid", 32'(p_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        // LSB-first 0xA5, consumer always ready
        p_ready = 1'b1;
        send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("a5_dout", 32'(p_dout), 32'hA5);
        chk("a5_valid", 32'(p_valid), 32'd1);
        tick();
        chk("a5_drop", 32'(p_valid), 32'd0);
        chk("a5_hold", 32'(p_dout), 32'hA5);

        // MSB-first 0x3C with strobe gaps
        send_word(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("3c_dout", 32'(p_dout), 32'h3C);
        chk("3c_valid", 32'(p_valid), 32'd1);
        tick();
        chk("3c_drop", 32'(p_valid), 32'd0);

        // Overrun: 0x11 held, 0x22 dropped
        p_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ov_dout1", 32'(p_dout), 32'h11);
        chk("ov_valid1", 32'(p_valid), 32'd1);
        send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ov_dout2", 32'(p_dout), 32'h11);
        chk("ov_flag", 32'(overrun), 32'd1);
        chk("ov_valid2", 32'(p_valid), 32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ov_clr", 32'(overrun), 32'd0);
        p_ready = 1'b1;
        tick();
        chk("ov_accept", 32'(p_valid), 32'd0);
        chk("ov_keep", 32'(p_dout), 32'h11);

        // Completion in the same cycle as acceptance
        p_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sim_dout", 32'(p_dout), 32'h22);
        chk("sim_valid", 32'(p_valid), 32'd1);
        chk("sim_ovr", 32'(overrun), 32'd0);
        tick();
        chk("sim_drain", 32'(p_valid), 32'd0);

        // Aborted frame after 5 bits, then 0x96
        partial = 5'b01011;
        for (int i = 0; i < 5; i++) begin
            s_din       = partial[i];
            frame_start = (i == 0);
            dir         = 1'b0;
            bit_en      = 1'b1;
            tick();
        end
        bit_en      = 1'b0;
        frame_start = 1'b0;
        chk("ab_busy", 32'(busy), 32'd1);
        chk("ab_valid", 32'(p_valid), 32'd0);
        chk("ab_ferr_idle", 32'(frame_err), 32'd0);
        send_word(8'h96, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ab_dout", 32'(p_dout), 32'h96);
        chk("ab_valid_end", 32'(p_valid), 32'd1);
        tick();
        chk("ab_drain", 32'(p_valid), 32'd0);

        // Reset mid-frame with a buffered word
        p_ready = 1'b0;
        send_word(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mr_valid", 32'(p_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            s_din       = 1'b1;
            frame_start = (i == 0);
            bit_en      = 1'b1;
            tick();
        end
        bit_en      = 1'b0;
        frame_start = 1'b0;
        chk("mr_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_dout", 32'(p_dout), 32'h0);
        chk("mr_valid0", 32'(p_valid), 32'd0);
        chk("mr_busy0", 32'(busy), 32'd0);
        chk("mr_ovr0", 32'(overrun), 32'd0);
        for (int i = 0; i < 8; i++) begin
            s_din  = 1'b1;
            bit_en = 1'b1;
            tick();
            chk("nofs_busy", 32'(busy), 32'd0);
            chk("nofs_valid", 32'(p_valid), 32'd0);
        end
        bit_en  = 1'b0;
        p_ready = 1'b1;
        send_word(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mr_dout_c3", 32'(p_dout), 32'hC3);
        chk("mr_valid_c3", 32'(p_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
